video_timing_gen: RTL and testbench

- Transmit-side counterpart of the video_sampling input interface: generates the pixel stream (vs/hs/de + rgb565) that a video_sampling instance consumes.
- Produces programmable raster timing and fetches active pixels from an upstream pixel FIFO (frame-buffer read path). It can substitute built-in test patterns (four-colour bars, ramp, solid fill).
- Sits between the DDR read FIFO and the HDMI/output encoder. Also serves as a synthesizable stimulus source for video_sampling.

---
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen.sv | 88 ++++++++
 tb/tb_video_timing_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pixel-FIFO read port, run controls and the vs/hs/de/rgb565 output stream.
interface video_timing_gen_if;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] fill_color;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
  logic        vs_out;
  logic        hs_out;
  logic        de_out;
  logic [15:0] rgb565_out;
  logic        frame_start;
  logic [15:0] underflow_cnt;
  modport master (
    input  en, mode, fill_color, fifo_rd_data, fifo_empty,
    output fifo_rd_en, vs_out, hs_out, de_out, rgb565_out, frame_start, underflow_cnt
  );
  modport slave (
    output en, mode, fill_color, fifo_rd_data, fifo_empty,
    input  fifo_rd_en, vs_out, hs_out, de_out, rgb565_out, frame_start, underflow_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing with FIFO-fed or test-pattern rgb565 pixels.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1
) (
  input logic clk,
  input logic rst,
  video_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_Q1   = HW'(H_ACTIVE / 4);
  localparam logic [HW-1:0] H_Q2   = HW'(H_ACTIVE / 2);
  localparam logic [HW-1:0] H_Q3   = HW'(3 * H_ACTIVE / 4);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic POL = SYNC_POL != 0;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_mode;
  logic          r_fifo_sel;
  logic [15:0]   r_rgb;
  logic          w_h_last, w_v_last, w_origin, w_act, w_hsync, w_vsync, w_rd, w_uf;
  logic [1:0]    w_mode;
  logic [15:0]   w_bar, w_pix;
  // At the frame origin the incoming mode is used directly so the first pixel matches the rest of the frame.
  always_comb begin
    w_h_last = r_h == H_LAST;
    w_v_last = r_v == V_LAST;
    w_origin = vid.en & (r_h == '0) & (r_v == '0);
    w_act    = vid.en & (r_h < H_ACT) & (r_v < V_ACT);
    w_hsync  = vid.en & (r_h >= H_S0) & (r_h < H_S1);
    w_vsync  = vid.en & (r_v >= V_S0) & (r_v < V_S1);
    w_mode   = w_origin ? vid.mode : r_mode;
    w_rd     = ~rst & w_act & (w_mode == 2'd0) & ~vid.fifo_empty;
    w_uf     = w_act & (w_mode == 2'd0) & vid.fifo_empty;
    w_bar    = r_h < H_Q1 ? 16'hF800 : r_h < H_Q2 ? 16'hFC00 : r_h < H_Q3 ? 16'hFFE0 : 16'h07E0;
    w_pix    = !w_act ? 16'h0000 :
               w_mode == 2'd1 ? w_bar :
               w_mode == 2'd2 ? 16'(r_h) + 16'd1 :
               w_mode == 2'd3 ? vid.fill_color : 16'h0000;
  end
  assign vid.fifo_rd_en = w_rd;
  // FIFO data only arrives in the output cycle, so it bypasses the pixel register.
  assign vid.rgb565_out = r_fifo_sel ? vid.fifo_rd_data : r_rgb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h               <= '0;
      r_v               <= '0;
      r_mode            <= 2'd0;
      r_fifo_sel        <= 1'b0;
      r_rgb             <= 16'h0000;
      vid.de_out        <= 1'b0;
      vid.hs_out        <= ~POL;
      vid.vs_out        <= ~POL;
      vid.frame_start   <= 1'b0;
      vid.underflow_cnt <= 16'h0000;
    end else begin
      r_h               <= (!vid.en || w_h_last) ? '0 : r_h + HW'(1);
      r_v               <= !vid.en ? '0 : !w_h_last ? r_v : w_v_last ? '0 : r_v + VW'(1);
      r_mode            <= w_origin ? vid.mode : r_mode;
      r_fifo_sel        <= w_rd;
      r_rgb             <= w_pix;
      vid.de_out        <= w_act;
      vid.hs_out        <= w_hsync ? POL : ~POL;
      vid.vs_out        <= w_vsync ? POL : ~POL;
      vid.frame_start   <= w_origin;
      vid.underflow_cnt <= !vid.en ? 16'h0000 :
                           w_origin ? {15'h0, w_uf} :
                           vid.underflow_cnt + {15'h0, w_uf && vid.underflow_cnt != 16'hFFFF};
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench; a small-raster DUT against a time-indexed raster model,
// plus a default-timing DUT checked over its first lines in ramp mode.
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2, VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  typedef struct packed {
    logic [3:0]  ctl;
    logic [15:0] rgb;
    logic [15:0] uc;
  } exp_t;
  localparam exp_t IDLE = '0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int errs = 0;
  int checks = 0;
  bit done2 = 1'b0;
  exp_t qo[$];
  logic qr[$];
  video_timing_gen_if v ();
  video_timing_gen_if v2 ();
  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
  ) dut (.clk(clk), .rst(rst), .vid(v));
  video_timing_gen dut2 (.clk(clk), .rst(rst2), .vid(v2));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [35:0] a, input logic [35:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  function automatic logic [15:0] bar(input int x);
    return x < HA / 4 ? 16'hF800 : x < HA / 2 ? 16'hFC00 : x < 3 * HA / 4 ? 16'hFFE0 : 16'h07E0;
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (qr.size() > 0) chk("fifo_rd_en", 36'(v.fifo_rd_en), 36'(qr.pop_front()));
    if (qo.size() > 0) begin
      e = qo.pop_front();
      chk("vs_hs_de_fs", 36'({v.vs_out, v.hs_out, v.de_out, v.frame_start}), 36'(e.ctl));
      chk("rgb565", 36'(v.rgb565_out), 36'(e.rgb));
      chk("underflow_cnt", 36'(v.underflow_cnt), 36'(e.uc));
    end
  end
  initial begin : drv
    int t, uc, h, ln;
    logic [1:0] fm, cm;
    logic [15:0] cf;
    logic r, e, fe, rd_prev, act, org, rd, uf;
    exp_t pend;
    logic [15:0] fq[$];
    t = 0; uc = 0; fm = 2'd0; cm = 2'd3; cf = 16'h1234; rd_prev = 1'b0; pend = IDLE;
    v.en = 1'b0; v.mode = 2'd0; v.fill_color = 16'h0; v.fifo_empty = 1'b1; v.fifo_rd_data = 16'h0;
    for (int k = 0; k < 3700; k++) begin
      @(posedge clk);
      #1;
      v.fifo_rd_data = (rd_prev && fq.size() > 0) ? fq.pop_front() : 16'($urandom);
      r = k < 3 || (k >= 661 && k < 664);
      e = 1'b1;
      fe = 1'b0;
      if (k < 205) begin
        e = k >= 3 && k < 203;
        cm = 2'd3;
        cf = 16'h1234;
      end else if (k < 405) begin
        cm = 2'd0;
        fe = t >= 115 && t <= 117;
      end else if (k < 664) begin
        cm = k < 550 ? 2'd1 : 2'd3;
        e = !(k >= 605 && k < 610);
      end else begin
        e = $urandom_range(0, 149) != 0;
        r = $urandom_range(0, 499) == 0;
        fe = $urandom_range(0, 5) == 0;
        if ($urandom_range(0, 29) == 0) cm = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) cf = 16'($urandom);
      end
      if (k == 204) begin
        fq.delete();
        for (int i = 1; i <= 32; i++) fq.push_back(16'(i));
      end
      if (k >= 295 && fq.size() < 6) fq.push_back(16'($urandom));
      qo.push_back(r ? IDLE : pend);
      rst = r;
      v.en = e;
      v.mode = cm;
      v.fill_color = cf;
      v.fifo_empty = fe || fq.size() == 0;
      #1;
      rd_prev = v.fifo_rd_en;
      if (r || !e) begin
        pend = IDLE;
        t = 0;
        uc = 0;
        qr.push_back(1'b0);
      end else begin
        h = t % HT;
        ln = (t / HT) % VT;
        org = h == 0 && ln == 0;
        if (org) fm = cm;
        act = h < HA && ln < VA;
        rd = act && fm == 2'd0 && !v.fifo_empty;
        uf = act && fm == 2'd0 && v.fifo_empty;
        if (org) uc = 0;
        if (uf && uc < 65535) uc++;
        pend.ctl = {ln >= VA + VF && ln < VA + VF + VS, h >= HA + HF && h < HA + HF + HS, act, org};
        pend.rgb = !act ? 16'h0 : fm == 2'd0 ? (rd ? fq[0] : 16'h0) :
                   fm == 2'd1 ? bar(h) : fm == 2'd2 ? 16'(h + 1) : cf;
        pend.uc = 16'(uc);
        qr.push_back(rd);
        t++;
      end
    end
    for (int i = 0; i < 5000 && !done2; i++) @(posedge clk);
    chk("dut2_finished", 36'(done2), 36'(1));
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  // Default 1650-clock lines in ramp mode: de for 1280 clocks carrying 1..1280, hsync at 1390..1429.
  initial begin : drv2
    int h;
    v2.en = 1'b0; v2.mode = 2'd2; v2.fill_color = 16'h0; v2.fifo_empty = 1'b1; v2.fifo_rd_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    v2.en = 1'b1;
    @(negedge clk);
    chk("dut2_idle", 36'({v2.vs_out, v2.hs_out, v2.de_out, v2.frame_start, v2.rgb565_out}), 36'(0));
    for (int t = 0; t < 3400; t++) begin
      @(negedge clk);
      h = t % 1650;
      chk("dut2_raster",
          36'({v2.vs_out, v2.hs_out, v2.de_out, v2.frame_start, v2.rgb565_out, v2.fifo_rd_en}),
          36'({1'b0, h >= 1390 && h < 1430, h < 1280, t == 0, h < 1280 ? 16'(h + 1) : 16'h0, 1'b0}));
    end
    done2 = 1'b1;
  end
endmodule
